// File: rtl/mc_pkg.sv
// Shared state, opcode and aluop definitions for the multicycle main decoder.
// Build option MC_MAINDEC_IMMLOGIC_EN routes andi/ori/slti through the immediate path.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX,
    ALUWB, BEQ, IMMEX, IMMWB, JMP, TRAP, BERR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       iord;
    logic       memToReg;
    logic       regDst;
    logic       aluSrcA;
    logic       branch;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] aluOp;
    logic       illegal;
    logic       busErr;
  } ctrl_t;

  function automatic logic [2:0] immAluOp(input logic [5:0] op6);
    case (op6)
      OP_ANDI: return ALUOP_AND;
      OP_ORI:  return ALUOP_OR;
      OP_SLTI: return ALUOP_SLT;
      default: return ALUOP_ADD;
    endcase
  endfunction

  // Strobes that depend on the state alone; FETCH completion strobes are added by the top.
  function automatic ctrl_t stateCtrl(input state_t s, input logic [5:0] op6);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  c.memReq = 1'b1;
      DECODE: c.aluSrcB = 2'b11;
      MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      MEMRD:  begin c.memReq = 1'b1; c.iord = 1'b1; end
      MEMWR:  begin c.memReq = 1'b1; c.iord = 1'b1; c.memWrite = 1'b1; end
      MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      RTEX:   begin c.aluSrcA = 1'b1; c.aluOp = ALUOP_FUNCT; end
      ALUWB:  begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      BEQ:    begin c.aluSrcA = 1'b1; c.branch = 1'b1; c.pcSrc = 2'b01; c.aluOp = ALUOP_SUB; end
      IMMEX:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = immAluOp(op6); end
      IMMWB:  c.regWrite = 1'b1;
      JMP:    begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
      TRAP:   c.illegal = 1'b1;
      BERR:   c.busErr = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_waitcnt.sv
// Memory wait counter: counts consecutive not-ready cycles of one access and
// flags expiry once TMO waits have elapsed and the access is still not ready.
module mc_waitcnt #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  output logic expired_o
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          atLimit;

  assign atLimit   = (cnt_q == CW'(TMO));
  assign expired_o = wait_i && atLimit;

  // Any cycle that is not a wait (ready, or outside a memory state) restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!wait_i) begin
      cnt_d = '0;
    end else if (!atLimit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS-style main decoder FSM with memory timeout and illegal-opcode traps.
// Build option MC_MAINDEC_IMMLOGIC_EN adds andi/ori/slti to the immediate path.
module mc_maindec
  import mc_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3,
  parameter int TMO    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    op,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              memwrite,
  output logic              pcwrite,
  output logic              irwrite,
  output logic              regwrite,
  output logic              iord,
  output logic              memtoreg,
  output logic              regdst,
  output logic              alusrca,
  output logic              branch,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [ALUOPW-1:0] aluop,
  output logic              illegal,
  output logic              bus_err
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [5:0] op6;
  logic       opUpperOk;
  logic       memState;
  logic       waitCycle;
  logic       expired;
  logic       fetchGo;

  assign op6 = op[5:0];

  if (OPW > 6) begin : gUpper
    assign opUpperOk = ~|op[OPW-1:6];
  end else begin : gNoUpper
    assign opUpperOk = 1'b1;
  end

  assign memState  = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign waitCycle = memState && !mem_ready;
  assign fetchGo   = (state_q == FETCH) && mem_ready;

  mc_waitcnt #(.TMO(TMO)) uWait (
    .clk      (clk),
    .reset    (reset),
    .wait_i   (waitCycle),
    .expired_o(expired)
  );

  // Completion is tested before expiry so a ready on the last allowed cycle wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (expired) state_d = BERR;
      end
      DECODE: begin
        if (!opUpperOk) begin
          state_d = TRAP;
        end else begin
          case (op6)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = RTEX;
            OP_BEQ:       state_d = BEQ;
            OP_ADDI:      state_d = IMMEX;
            OP_J:         state_d = JMP;
`ifdef MC_MAINDEC_IMMLOGIC_EN
            OP_ANDI, OP_ORI, OP_SLTI: state_d = IMMEX;
`endif
            default:      state_d = TRAP;
          endcase
        end
      end
      MEMADR: state_d = (op6 == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)    state_d = MEMWB;
        else if (expired) state_d = BERR;
      end
      MEMWR: begin
        if (mem_ready)    state_d = FETCH;
        else if (expired) state_d = BERR;
      end
      RTEX:    state_d = ALUWB;
      IMMEX:   state_d = IMMWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= stateCtrl(FETCH, op6);
    end else begin
      state_q <= state_d;
      ctrl_q  <= stateCtrl(state_d, op6);
    end
  end

  // Reset forces every output low regardless of the state being left.
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = '0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (!reset) begin
      mem_req  = ctrl_q.memReq;
      memwrite = ctrl_q.memWrite;
      pcwrite  = ctrl_q.pcWrite | fetchGo;
      irwrite  = fetchGo;
      regwrite = ctrl_q.regWrite;
      iord     = ctrl_q.iord;
      memtoreg = ctrl_q.memToReg;
      regdst   = ctrl_q.regDst;
      alusrca  = ctrl_q.aluSrcA;
      branch   = ctrl_q.branch;
      alusrcb  = fetchGo ? 2'b01 : ctrl_q.aluSrcB;
      pcsrc    = ctrl_q.pcSrc;
      aluop    = ALUOPW'(ctrl_q.aluOp);
      illegal  = ctrl_q.illegal;
      bus_err  = ctrl_q.busErr;
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: directed corner sequences plus random
// instruction streams checked against an instruction-level trace model.
module tb_mc_maindec;

  localparam int TMO = 4;

  localparam logic [5:0] L_RTYPE = 6'b000000;
  localparam logic [5:0] L_LW    = 6'b100011;
  localparam logic [5:0] L_SW    = 6'b101011;
  localparam logic [5:0] L_BEQ   = 6'b000100;
  localparam logic [5:0] L_ADDI  = 6'b001000;
  localparam logic [5:0] L_J     = 6'b000010;
  localparam logic [5:0] L_ANDI  = 6'b001100;
  localparam logic [5:0] L_ORI   = 6'b001101;
  localparam logic [5:0] L_SLTI  = 6'b001010;
  localparam logic [5:0] L_ILL   = 6'b011110;

`ifdef MC_MAINDEC_IMMLOGIC_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, pcwrite, irwrite, regwrite, iord, memtoreg;
  logic       regdst, alusrca, branch, illegal, bus_err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  mc_maindec #(.OPW(6), .ALUOPW(3), .TMO(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .memwrite (memwrite),
    .pcwrite  (pcwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrca  (alusrca),
    .branch   (branch),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memReq, memWrite, pcWrite, irWrite, regWrite, iord, memToReg, regDst, aluSrcA, branch;
    logic [1:0] aluSrcB, pcSrc;
    logic [2:0] aluOp;
    logic       illegal, busErr;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];
  vec_t trace[$];
  int   applied = 0;
  int   miscompares = 0;

  // Expected output pattern of each step of an instruction.
  function automatic outs_t oZero();      outs_t o = '0; return o; endfunction
  function automatic outs_t oFetchWait(); outs_t o = '0; o.memReq = 1; return o; endfunction
  function automatic outs_t oFetchDone();
    outs_t o = '0; o.memReq = 1; o.irWrite = 1; o.pcWrite = 1; o.aluSrcB = 2'b01; return o;
  endfunction
  function automatic outs_t oDecode();    outs_t o = '0; o.aluSrcB = 2'b11; return o; endfunction
  function automatic outs_t oMemAdr();    outs_t o = '0; o.aluSrcA = 1; o.aluSrcB = 2'b10; return o; endfunction
  function automatic outs_t oMemRd();     outs_t o = '0; o.memReq = 1; o.iord = 1; return o; endfunction
  function automatic outs_t oMemWr();     outs_t o = '0; o.memReq = 1; o.iord = 1; o.memWrite = 1; return o; endfunction
  function automatic outs_t oMemWb();     outs_t o = '0; o.regWrite = 1; o.memToReg = 1; return o; endfunction
  function automatic outs_t oRtex();      outs_t o = '0; o.aluSrcA = 1; o.aluOp = 3'b010; return o; endfunction
  function automatic outs_t oAluWb();     outs_t o = '0; o.regDst = 1; o.regWrite = 1; return o; endfunction
  function automatic outs_t oBeq();
    outs_t o = '0; o.aluSrcA = 1; o.branch = 1; o.pcSrc = 2'b01; o.aluOp = 3'b001; return o;
  endfunction
  function automatic outs_t oImmEx(input logic [2:0] a);
    outs_t o = '0; o.aluSrcA = 1; o.aluSrcB = 2'b10; o.aluOp = a; return o;
  endfunction
  function automatic outs_t oImmWb();     outs_t o = '0; o.regWrite = 1; return o; endfunction
  function automatic outs_t oJmp();       outs_t o = '0; o.pcWrite = 1; o.pcSrc = 2'b10; return o; endfunction
  function automatic outs_t oTrap();      outs_t o = '0; o.illegal = 1; return o; endfunction
  function automatic outs_t oBerr();      outs_t o = '0; o.busErr = 1; return o; endfunction

  task automatic pushVec(input logic rst, input logic [5:0] opv, input logic rdy, input outs_t e);
    vec_t v;
    v.rst = rst; v.op = opv; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic addTrace(input logic [5:0] opv, input logic rdy, input outs_t e);
    vec_t v;
    v.rst = 1'b0; v.op = opv; v.rdy = rdy; v.exp = e;
    trace.push_back(v);
  endtask

  // One memory access that sees w not-ready cycles; more than TMO waits ends in a bus error.
  task automatic modelAccess(input logic [5:0] opv, input outs_t waitO, input outs_t doneO,
                             input int w, output bit fault);
    if (w > TMO) begin
      for (int i = 0; i <= TMO; i++) addTrace(opv, 1'b0, waitO);
      addTrace(opv, 1'($urandom_range(0, 1)), oBerr());
      fault = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) addTrace(opv, 1'b0, waitO);
      addTrace(opv, 1'b1, doneO);
      fault = 1'b0;
    end
  endtask

  task automatic modelInstr(input logic [5:0] opv, input int fw, input int dw);
    bit f;
    modelAccess(opv, oFetchWait(), oFetchDone(), fw, f);
    if (!f) begin
      addTrace(opv, 1'($urandom_range(0, 1)), oDecode());
      case (opv)
        L_LW: begin
          addTrace(opv, 1'($urandom_range(0, 1)), oMemAdr());
          modelAccess(opv, oMemRd(), oMemRd(), dw, f);
          if (!f) addTrace(opv, 1'($urandom_range(0, 1)), oMemWb());
        end
        L_SW: begin
          addTrace(opv, 1'($urandom_range(0, 1)), oMemAdr());
          modelAccess(opv, oMemWr(), oMemWr(), dw, f);
        end
        L_RTYPE: begin addTrace(opv, 1'b1, oRtex()); addTrace(opv, 1'b0, oAluWb()); end
        L_BEQ:   addTrace(opv, 1'b1, oBeq());
        L_J:     addTrace(opv, 1'b0, oJmp());
        L_ADDI:  begin addTrace(opv, 1'b1, oImmEx(3'b000)); addTrace(opv, 1'b0, oImmWb()); end
        L_ANDI, L_ORI, L_SLTI: begin
          if (IMM_EN) begin
            addTrace(opv, 1'b0, oImmEx(opv == L_ANDI ? 3'b011 : (opv == L_ORI ? 3'b100 : 3'b101)));
            addTrace(opv, 1'b1, oImmWb());
          end else begin
            addTrace(opv, 1'b0, oTrap());
          end
        end
        default: addTrace(opv, 1'b1, oTrap());
      endcase
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset     = v.rst;
    op        = v.op;
    mem_ready = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    outs_t got;
    @(negedge clk);
    got = {mem_req, memwrite, pcwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, branch, alusrcb, pcsrc, aluop, illegal, bus_err};
    applied++;
    if (got !== v.exp) begin
      miscompares++;
      $display("[TB] FAIL vec[%0d] op=%b rdy=%b rst=%b got=%b want=%b",
               idx, v.op, v.rdy, v.rst, got, v.exp);
    end
  endtask

  initial begin
    logic [5:0] opList[9];
    opList[0] = L_RTYPE; opList[1] = L_LW;   opList[2] = L_SW;
    opList[3] = L_BEQ;   opList[4] = L_ADDI; opList[5] = L_J;
    opList[6] = L_ANDI;  opList[7] = L_ORI;  opList[8] = L_SLTI;

    // Reset cycle, then lw with every access ready at once.
    pushVec(1, L_LW, 0, oZero());
    pushVec(0, L_LW, 1, oFetchDone());
    pushVec(0, L_LW, 0, oDecode());
    pushVec(0, L_LW, 1, oMemAdr());
    pushVec(0, L_LW, 1, oMemRd());
    pushVec(0, L_LW, 0, oMemWb());
    // sw with three wait cycles on the data access.
    pushVec(0, L_SW, 1, oFetchDone());
    pushVec(0, L_SW, 1, oDecode());
    pushVec(0, L_SW, 0, oMemAdr());
    for (int i = 0; i < 3; i++) pushVec(0, L_SW, 0, oMemWr());
    pushVec(0, L_SW, 1, oMemWr());
    pushVec(0, L_ILL, 0, oFetchWait());
    // Illegal opcode traps once.
    pushVec(0, L_ILL, 1, oFetchDone());
    pushVec(0, L_ILL, 0, oDecode());
    pushVec(0, L_ILL, 1, oTrap());
    // Fetch stuck not-ready: TMO waits, one more, then a single bus error.
    for (int i = 0; i <= TMO; i++) pushVec(0, L_ORI, 0, oFetchWait());
    pushVec(0, L_ORI, 0, oBerr());
    // Ready arriving exactly at the limit completes without a bus error.
    for (int i = 0; i < TMO; i++) pushVec(0, L_ORI, 0, oFetchWait());
    pushVec(0, L_ORI, 1, oFetchDone());
    pushVec(0, L_ORI, 0, oDecode());
    if (IMM_EN) begin
      pushVec(0, L_ORI, 0, oImmEx(3'b100));
      pushVec(0, L_ORI, 0, oImmWb());
    end else begin
      pushVec(0, L_ORI, 0, oTrap());
    end
    pushVec(0, L_RTYPE, 1, oFetchDone()); pushVec(0, L_RTYPE, 0, oDecode());
    pushVec(0, L_RTYPE, 0, oRtex());      pushVec(0, L_RTYPE, 0, oAluWb());
    pushVec(0, L_BEQ, 1, oFetchDone());   pushVec(0, L_BEQ, 0, oDecode());
    pushVec(0, L_BEQ, 0, oBeq());
    pushVec(0, L_J, 1, oFetchDone());     pushVec(0, L_J, 0, oDecode());
    pushVec(0, L_J, 0, oJmp());
    pushVec(0, L_ADDI, 1, oFetchDone());  pushVec(0, L_ADDI, 0, oDecode());
    pushVec(0, L_ADDI, 0, oImmEx(3'b000)); pushVec(0, L_ADDI, 0, oImmWb());
    // Reset in the middle of a write wait; the counter must restart from zero.
    pushVec(0, L_SW, 1, oFetchDone());    pushVec(0, L_SW, 0, oDecode());
    pushVec(0, L_SW, 0, oMemAdr());
    pushVec(0, L_SW, 0, oMemWr());        pushVec(0, L_SW, 0, oMemWr());
    pushVec(1, L_SW, 0, oZero());
    for (int i = 0; i < TMO; i++) pushVec(0, L_ILL, 0, oFetchWait());
    pushVec(0, L_ILL, 1, oFetchDone());
    // Reset landing on the trap cycle suppresses the pulse.
    pushVec(0, L_ILL, 0, oDecode());
    pushVec(1, L_ILL, 1, oZero());
    pushVec(1, L_ILL, 1, oZero());
    pushVec(0, L_J, 1, oFetchDone());     pushVec(0, L_J, 0, oDecode());
    pushVec(0, L_J, 0, oJmp());

    // Random instruction stream, occasionally cut short by a reset.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] opv;
      int fw, dw, k;
      k   = $urandom_range(0, 11);
      opv = (k < 9) ? opList[k] : 6'($urandom_range(0, 63));
      fw  = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      dw  = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, TMO);
      trace.delete();
      modelInstr(opv, fw, dw);
      if ($urandom_range(0, 15) == 0) begin
        int cut;
        cut = $urandom_range(0, trace.size() - 1);
        for (int i = 0; i < cut; i++) vecs.push_back(trace[i]);
        pushVec(1, opv, 1'($urandom_range(0, 1)), oZero());
      end else begin
        for (int i = 0; i < trace.size(); i++) vecs.push_back(trace[i]);
      end
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
